// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU among N_REQ requesters.
// One operation in flight: the winner's operands are latched at grant, the
// ALU is driven from those registers, and the result is returned on a
// per-requester valid/ready response channel.
//
// state | meaning
// IDLE  | arbitrating; req_ready one-hot on the round-robin winner
// EXEC  | ALU driven from latched operands; result captured at the edge
// RESP  | rsp_valid held for the granted requester until its rsp_ready
module alu_arbiter #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(N_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ-1:0][1:0]         req_ctrl,
  input  logic [N_REQ-1:0][DATA_W-1:0]  req_in_1,
  input  logic [N_REQ-1:0][DATA_W-1:0]  req_in_2,
  output logic [1:0]                    alu_ctrl,
  output logic [DATA_W-1:0]             alu_in_1,
  output logic [DATA_W-1:0]             alu_in_2,
  input  logic [DATA_W-1:0]             alu_out,
  input  logic                          alu_zero,
  output logic [N_REQ-1:0]              rsp_valid,
  input  logic [N_REQ-1:0]              rsp_ready,
  output logic [DATA_W-1:0]             rsp_out,
  output logic                          rsp_zero,
  output logic                          busy
);

  localparam logic [1:0] OP_AND = 2'b00;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_grant_q;
  logic [IDX_W-1:0]   grant_q;
  logic [1:0]         op_q;
  logic [DATA_W-1:0]  in_1_q, in_2_q;
  logic [DATA_W-1:0]  rsp_out_q;
  logic               rsp_zero_q;

  logic               found;
  logic [IDX_W-1:0]   win;
  logic               accept;
  logic               rsp_done;

  // Round-robin search starting just above the previous winner, wrapping.
  always_comb begin
    int j;
    found = 1'b0;
    win   = '0;
    j     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(last_grant_q) + 1 + k) % N_REQ;
      if (!found && req_valid[j]) begin
        found = 1'b1;
        win   = IDX_W'(j);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    rsp_valid = '0;
    accept    = 1'b0;
    rsp_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          req_ready = {{(N_REQ-1){1'b0}}, 1'b1} << win;
          accept    = 1'b1;
          state_d   = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        rsp_valid = {{(N_REQ-1){1'b0}}, 1'b1} << grant_q;
        if (rsp_ready[grant_q]) begin
          rsp_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch at grant, result capture at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= IDX_W'(N_REQ-1);
      grant_q      <= '0;
      op_q         <= OP_AND;
      in_1_q       <= '0;
      in_2_q       <= '0;
      rsp_out_q    <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q         <= req_ctrl[win];
        in_1_q       <= req_in_1[win];
        in_2_q       <= req_in_2[win];
        grant_q      <= win;
        last_grant_q <= win;
      end
      if (state_q == EXEC) begin
        rsp_out_q  <= alu_out;
        rsp_zero_q <= alu_zero;
      end
    end
  end

  assign alu_ctrl = op_q;
  assign alu_in_1 = in_1_q;
  assign alu_in_2 = in_2_q;
  assign rsp_out  = rsp_out_q;
  assign rsp_zero = rsp_zero_q;
  assign busy     = (state_q != IDLE);

endmodule
